// File: rtl/i2c_target_regs.sv
// I2C target exposing NREGS 8-bit registers behind a byte pointer with auto-increment.
// SCL/SDA are synchronized and majority-filtered; SDA is driven open-drain, changing only on SCL falling.
module i2c_target_regs #(
  parameter logic [6:0]  DEV_ADDR = 7'h50,
  parameter int unsigned NREGS    = 4,
  parameter logic [7:0]  RST_VAL  = 8'h00
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     scl_i,
  input  logic                     sda_i,
  output logic                     sda_o,
  output logic [8*NREGS-1:0]       regs_o,
  output logic                     wr_stb_o,
  output logic [$clog2(NREGS)-1:0] wr_idx_o,
  output logic                     busy_o
);
  localparam int unsigned PW = $clog2(NREGS);
  localparam int unsigned RW = 8 * NREGS;

  typedef enum logic [3:0] {
    IDLE, ADDR, ACK_A, PTR, ACK_P, WR, ACK_W, RD, MACK, IGNORE
  } state_e;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  logic [1:0]    scl_sync_q, scl_sync_d, sda_sync_q, sda_sync_d;
  logic [1:0]    scl_hist_q, scl_hist_d, sda_hist_q, sda_hist_d;
  logic          scl_f_q, scl_f_d, sda_f_q, sda_f_d;
  logic          scl_p_q, scl_p_d, sda_p_q, sda_p_d;

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    tx_q, tx_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [RW-1:0] regs_q, regs_d;
  logic          sda_q, sda_d;
  logic          wr_stb_q, wr_stb_d;
  logic [PW-1:0] wr_idx_q, wr_idx_d;
  logic          busy_q, busy_d;
  logic          rw_q, rw_d;
  logic          nack_q, nack_d;

  logic          scl_rise_c, scl_fall_c, start_c, stop_c;
  logic [7:0]    cur_byte_c;

  // Input conditioning: 2-FF sync, then majority of three consecutive synced samples
  always_comb begin
    scl_sync_d = {scl_sync_q[0], scl_i};
    sda_sync_d = {sda_sync_q[0], sda_i};
    scl_hist_d = {scl_hist_q[0], scl_sync_q[1]};
    sda_hist_d = {sda_hist_q[0], sda_sync_q[1]};
    scl_f_d    = maj3(scl_sync_q[1], scl_hist_q[0], scl_hist_q[1]);
    sda_f_d    = maj3(sda_sync_q[1], sda_hist_q[0], sda_hist_q[1]);
    scl_p_d    = scl_f_q;
    sda_p_d    = sda_f_q;
  end

  assign scl_rise_c = scl_f_q & ~scl_p_q;
  assign scl_fall_c = ~scl_f_q & scl_p_q;
  assign start_c    = scl_f_q & sda_p_q & ~sda_f_q;
  assign stop_c     = scl_f_q & ~sda_p_q & sda_f_q;
  assign cur_byte_c = regs_q[{ptr_q, 3'b000} +: 8];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shift_d  = shift_q;
    tx_d     = tx_q;
    ptr_d    = ptr_q;
    regs_d   = regs_q;
    sda_d    = sda_q;
    wr_stb_d = 1'b0;
    wr_idx_d = wr_idx_q;
    busy_d   = busy_q;
    rw_d     = rw_q;
    nack_d   = nack_q;
    // START/STOP take priority over any SCL edge seen in the same cycle
    if (stop_c) begin
      state_d = IDLE;
      busy_d  = 1'b0;
      sda_d   = 1'b1;
      cnt_d   = 4'd0;
    end else if (start_c) begin
      state_d = ADDR;
      busy_d  = 1'b1;
      sda_d   = 1'b1;
      cnt_d   = 4'd0;
    end else begin
      case (state_q)
        ADDR, PTR, WR: begin
          if (scl_rise_c && cnt_q != 4'd8) begin
            shift_d = {shift_q[6:0], sda_f_q};
            cnt_d   = cnt_q + 4'd1;
          end else if (scl_fall_c && cnt_q == 4'd8) begin
            cnt_d = 4'd0;
            if (state_q == ADDR) begin
              if (shift_q[7:1] == DEV_ADDR) begin
                sda_d   = 1'b0;
                rw_d    = shift_q[0];
                state_d = ACK_A;
              end else begin
                state_d = IGNORE;
              end
            end else if (state_q == PTR) begin
              ptr_d   = shift_q[PW-1:0];
              sda_d   = 1'b0;
              state_d = ACK_P;
            end else begin
              regs_d[{ptr_q, 3'b000} +: 8] = shift_q;
              wr_stb_d = 1'b1;
              wr_idx_d = ptr_q;
              ptr_d    = ptr_q + PW'(1);
              sda_d    = 1'b0;
              state_d  = ACK_W;
            end
          end
        end
        ACK_A: begin
          if (scl_fall_c) begin
            if (rw_q) begin
              sda_d   = cur_byte_c[7];
              tx_d    = {cur_byte_c[6:0], 1'b0};
              cnt_d   = 4'd0;
              state_d = RD;
            end else begin
              sda_d   = 1'b1;
              state_d = PTR;
            end
          end
        end
        ACK_P, ACK_W: begin
          if (scl_fall_c) begin
            sda_d   = 1'b1;
            state_d = WR;
          end
        end
        RD: begin
          if (scl_fall_c) begin
            if (cnt_q == 4'd7) begin
              sda_d   = 1'b1;
              ptr_d   = ptr_q + PW'(1);
              cnt_d   = 4'd0;
              state_d = MACK;
            end else begin
              sda_d = tx_q[7];
              tx_d  = {tx_q[6:0], 1'b0};
              cnt_d = cnt_q + 4'd1;
            end
          end
        end
        MACK: begin
          if (scl_rise_c) begin
            nack_d = sda_f_q;
          end else if (scl_fall_c) begin
            if (!nack_q) begin
              sda_d   = cur_byte_c[7];
              tx_d    = {cur_byte_c[6:0], 1'b0};
              cnt_d   = 4'd0;
              state_d = RD;
            end else begin
              state_d = IGNORE;
            end
          end
        end
        IGNORE:  sda_d = 1'b1;
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
      scl_hist_q <= 2'b11;
      sda_hist_q <= 2'b11;
      scl_f_q    <= 1'b1;
      sda_f_q    <= 1'b1;
      scl_p_q    <= 1'b1;
      sda_p_q    <= 1'b1;
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      shift_q    <= 8'h00;
      tx_q       <= 8'h00;
      ptr_q      <= '0;
      regs_q     <= {NREGS{RST_VAL}};
      sda_q      <= 1'b1;
      wr_stb_q   <= 1'b0;
      wr_idx_q   <= '0;
      busy_q     <= 1'b0;
      rw_q       <= 1'b0;
      nack_q     <= 1'b1;
    end else begin
      scl_sync_q <= scl_sync_d;
      sda_sync_q <= sda_sync_d;
      scl_hist_q <= scl_hist_d;
      sda_hist_q <= sda_hist_d;
      scl_f_q    <= scl_f_d;
      sda_f_q    <= sda_f_d;
      scl_p_q    <= scl_p_d;
      sda_p_q    <= sda_p_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      ptr_q      <= ptr_d;
      regs_q     <= regs_d;
      sda_q      <= sda_d;
      wr_stb_q   <= wr_stb_d;
      wr_idx_q   <= wr_idx_d;
      busy_q     <= busy_d;
      rw_q       <= rw_d;
      nack_q     <= nack_d;
    end
  end

  assign sda_o    = sda_q;
  assign regs_o   = regs_q;
  assign wr_stb_o = wr_stb_q;
  assign wr_idx_o = wr_idx_q;
  assign busy_o   = busy_q;

endmodule

// File: tb/tb_i2c_target_regs.sv
// Bench for i2c_target_regs: a bit-banged I2C master drives the bus; expected ACKs, read bytes
// and register writes are queued at issue time and checked by separate monitor processes.
module tb_i2c_target_regs;
  localparam int Q = 10;

  logic        clk = 1'b0;
  logic        rst_n, scl, msda;
  logic        sda_o, wr_stb_o, busy_o;
  logic [31:0] regs_o;
  logic [1:0]  wr_idx_o;
  logic        sda_bus;

  int total = 0;
  int bad   = 0;

  logic [15:0] exp_wr_q[$];
  logic [7:0]  exp_bus_q[$];
  logic [7:0]  obs_bus_q[$];
  string       nm_q[$];
  logic        ign_win = 1'b0;
  int          sda_low_cnt = 0;

  assign sda_bus = msda & sda_o;

  always #5 clk = ~clk;

  i2c_target_regs #(.DEV_ADDR(7'h50), .NREGS(4), .RST_VAL(8'h00)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .scl_i    (scl),
    .sda_i    (sda_bus),
    .sda_o    (sda_o),
    .regs_o   (regs_o),
    .wr_stb_o (wr_stb_o),
    .wr_idx_o (wr_idx_o),
    .busy_o   (busy_o)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, expv);
    end
  endtask

  // Register-write monitor: every wr_stb_o must match the next queued write
  always @(negedge clk) begin
    if (wr_stb_o) begin
      if (exp_wr_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL wr_stb unexpected: got idx %0d, expected no write", wr_idx_o);
      end else begin
        chk("wr_stb idx/data", {16'h0, 8'(wr_idx_o), regs_o[{wr_idx_o, 3'b000} +: 8]},
            {16'h0, exp_wr_q.pop_front()});
      end
    end
  end

  // Bus monitor: compares observed ACK bits and read bytes against expectations
  always @(negedge clk) begin
    if (obs_bus_q.size() > 0) begin
      if (exp_bus_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL bus unexpected: got %h expected nothing", obs_bus_q.pop_front());
      end else begin
        chk(nm_q.pop_front(), {24'h0, obs_bus_q.pop_front()}, {24'h0, exp_bus_q.pop_front()});
      end
    end
  end

  always @(negedge clk) begin
    if (ign_win && !sda_o) sda_low_cnt++;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic hq();
    repeat (Q) @(negedge clk);
  endtask

  task automatic i2c_start();
    msda = 1'b1; hq();
    scl  = 1'b1; hq();
    msda = 1'b0; hq();
    scl  = 1'b0; hq();
  endtask

  task automatic i2c_stop();
    msda = 1'b0; hq();
    scl  = 1'b1; hq();
    msda = 1'b1; hq();
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      msda = b[7-i]; hq();
      scl = 1'b1; hq(); hq();
      scl = 1'b0; hq();
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic expack, input string nm);
    logic a;
    exp_bus_q.push_back(8'(expack));
    nm_q.push_back(nm);
    send_bits(b, 8);
    msda = 1'b1; hq();
    scl = 1'b1; hq();
    a = sda_bus; hq();
    scl = 1'b0; hq();
    obs_bus_q.push_back(8'(a));
  endtask

  task automatic read_byte(input logic ack, input logic [7:0] expv, input string nm);
    logic [7:0] b;
    exp_bus_q.push_back(expv);
    nm_q.push_back(nm);
    msda = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      hq();
      scl = 1'b1; hq();
      b[i] = sda_bus; hq();
      scl = 1'b0;
    end
    msda = ack; hq();
    scl = 1'b1; hq(); hq();
    scl = 1'b0;
    msda = 1'b1; hq();
    obs_bus_q.push_back(b);
  endtask

  initial begin
    rst_n = 1'b0;
    scl   = 1'b1;
    msda  = 1'b1;
    repeat (5) @(negedge clk);
    chk("reset sda_o", 32'(sda_o), 32'h1);
    chk("reset regs", regs_o, 32'h0);
    chk("reset busy", 32'(busy_o), 32'h0);
    chk("reset wr_stb", 32'(wr_stb_o), 32'h0);
    rst_n = 1'b1;
    hq();

    // Single-byte write to reg 1
    i2c_start();
    chk("t1 busy after start", 32'(busy_o), 32'h1);
    send_byte(8'hA0, 1'b0, "t1 addr ack");
    send_byte(8'h01, 1'b0, "t1 ptr ack");
    exp_wr_q.push_back({8'd1, 8'h5A});
    send_byte(8'h5A, 1'b0, "t1 data ack");
    i2c_stop();
    chk("t1 busy after stop", 32'(busy_o), 32'h0);
    chk("t1 regs", regs_o, 32'h0000_5A00);

    // Pointer write, repeated start, read one byte with NACK
    i2c_start();
    send_byte(8'hA0, 1'b0, "t2 addr ack");
    send_byte(8'h01, 1'b0, "t2 ptr ack");
    i2c_start();
    send_byte(8'hA1, 1'b0, "t2 addr-r ack");
    read_byte(1'b1, 8'h5A, "t2 read byte");
    chk("t2 sda released after nack", 32'(sda_o), 32'h1);
    i2c_stop();

    // Foreign address: target must stay silent
    ign_win = 1'b1;
    i2c_start();
    send_byte(8'hA2, 1'b1, "t3 addr nack");
    send_byte(8'h00, 1'b1, "t3 ptr nack");
    send_byte(8'h11, 1'b1, "t3 data nack");
    i2c_stop();
    ign_win = 1'b0;
    chk("t3 sda never low", 32'(sda_low_cnt), 32'h0);
    chk("t3 regs unchanged", regs_o, 32'h0000_5A00);

    // Write burst wrapping from reg 3 to reg 0
    i2c_start();
    send_byte(8'hA0, 1'b0, "t4 addr ack");
    send_byte(8'h03, 1'b0, "t4 ptr ack");
    exp_wr_q.push_back({8'd3, 8'hC3});
    send_byte(8'hC3, 1'b0, "t4 data0 ack");
    exp_wr_q.push_back({8'd0, 8'h3C});
    send_byte(8'h3C, 1'b0, "t4 data1 ack");
    i2c_stop();
    chk("t4 regs", regs_o, 32'hC300_5A3C);
    // Read without setting the pointer: ptr must have wrapped to 1
    i2c_start();
    send_byte(8'hA1, 1'b0, "t4 ptr-check addr ack");
    read_byte(1'b1, 8'h5A, "t4 ptr==1 read");
    i2c_stop();

    // Burst read wrapping 3 -> 0 -> 1
    i2c_start();
    send_byte(8'hA0, 1'b0, "t5 addr ack");
    send_byte(8'h03, 1'b0, "t5 ptr ack");
    i2c_start();
    send_byte(8'hA1, 1'b0, "t5 addr-r ack");
    read_byte(1'b0, 8'hC3, "t5 read0");
    read_byte(1'b0, 8'h3C, "t5 read1");
    read_byte(1'b1, 8'h5A, "t5 read2");
    chk("t5 sda released after nack", 32'(sda_o), 32'h1);
    i2c_stop();

    // STOP after half a data byte leaves registers alone
    i2c_start();
    send_byte(8'hA0, 1'b0, "t6 addr ack");
    send_byte(8'h02, 1'b0, "t6 ptr ack");
    send_bits(8'hFF, 4);
    i2c_stop();
    chk("t6 abort regs", regs_o, 32'hC300_5A3C);
    chk("t6 abort busy", 32'(busy_o), 32'h0);

    // Reset while the target is driving a read bit (reg 0 = 0x3C, bit7 = 0)
    i2c_start();
    send_byte(8'hA0, 1'b0, "t6 rd addr ack");
    send_byte(8'h00, 1'b0, "t6 rd ptr ack");
    i2c_start();
    send_byte(8'hA1, 1'b0, "t6 rd addr-r ack");
    chk("t6 driving bit7 before reset", 32'(sda_o), 32'h0);
    rst_n = 1'b0;
    #1;
    chk("t6 sda_o async reset", 32'(sda_o), 32'h1);
    chk("t6 regs async reset", regs_o, 32'h0);
    @(negedge clk);
    chk("t6 busy after reset", 32'(busy_o), 32'h0);
    scl  = 1'b1;
    msda = 1'b1;
    hq();
    rst_n = 1'b1;
    hq();

    repeat (20) @(negedge clk);
    chk("wr queue drained", 32'(exp_wr_q.size()), 32'h0);
    chk("bus queue drained", 32'(exp_bus_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
